// File: rtl/vram_blitter_pkg.sv
// Shared types and defaults for the sprite/clear blitter: FSM encoding,
// read-modify-write operations and geometry defaults.
package vram_blitter_pkg;

  localparam int HBITS_DEF     = 7;
  localparam int VBITS_DEF     = 6;
  localparam int AW_DEF        = 12;
  localparam int SPRITE16_ROWS = 16;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_LATCH  = 4'd2,
    ST_PIX_RD = 4'd3,
    ST_PIX_WR = 4'd4,
    ST_SKIP   = 4'd5,
    ST_FINISH = 4'd6,
    ST_CLR_RD = 4'd7,
    ST_CLR_WR = 4'd8
  } blit_state_e;

  typedef enum logic {
    RMW_XOR  = 1'b0,
    RMW_ANDN = 1'b1
  } rmw_op_e;

  // Draw toggles the masked planes; clear knocks them out.
  function automatic logic [1:0] rmw_apply(rmw_op_e op, logic [1:0] old_px,
                                           logic [1:0] mask);
    return (op == RMW_XOR) ? (old_px ^ mask) : (old_px & ~mask);
  endfunction

endpackage

// File: rtl/vram_blitter_if.sv
// Pixel read-modify-write port between the blitter (master) and vram (slave).
interface vram_blitter_if
  import vram_blitter_pkg::*;
#(
  parameter int HBITS = HBITS_DEF,
  parameter int VBITS = VBITS_DEF
);
  logic [HBITS-1:0] vram_hpos;
  logic [VBITS-1:0] vram_vpos;
  logic [1:0]       vram_pixeli;
  logic [1:0]       vram_pixelo;
  logic             vram_we;

  modport master (
    output vram_hpos, vram_vpos, vram_pixeli, vram_we,
    input  vram_pixelo
  );

  modport slave (
    input  vram_hpos, vram_vpos, vram_pixeli, vram_we,
    output vram_pixelo
  );
endinterface

// File: rtl/vram_blitter_rmw_seq.sv
// Write half of the 2-cycle vram read/modify/write pair: applies xor/andn under
// the plane mask to the pixel read back and accumulates the collision flag.
module vram_blitter_rmw_seq
  import vram_blitter_pkg::*;
#(
  parameter int HBITS = HBITS_DEF,
  parameter int VBITS = VBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [HBITS-1:0] hpos_i,
  input  logic [VBITS-1:0] vpos_i,
  input  logic             wr_i,
  input  rmw_op_e          op_i,
  input  logic [1:0]       mask_i,
  input  logic             coll_clr_i,
  output logic             collision_o,
  vram_blitter_if.master   vram
);

  logic collision_q, collision_d;
  logic hit;

  // Address is held by the caller across RD and WR, so pixelo in the WR
  // cycle is the value of the pixel being rewritten.
  always_comb begin
    vram.vram_hpos   = hpos_i;
    vram.vram_vpos   = vpos_i;
    vram.vram_we     = wr_i;
    vram.vram_pixeli = rmw_apply(op_i, vram.vram_pixelo, mask_i);
  end

  assign hit = wr_i && (op_i == RMW_XOR) && (|(vram.vram_pixelo & mask_i));

  always_comb begin
    collision_d = collision_q;
    if (coll_clr_i) begin
      collision_d = 1'b0;
    end else if (hit) begin
      collision_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

endmodule

// File: rtl/vram_blitter.sv
// Sprite draw / screen clear engine: command latch, row/column counters,
// sprite shift register and the sequencing FSM driving the vram RMW port.
module vram_blitter
  import vram_blitter_pkg::*;
#(
  parameter int HBITS = HBITS_DEF,
  parameter int VBITS = VBITS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             draw_start,
  input  logic             clr_start,
  input  logic [HBITS-1:0] x,
  input  logic [VBITS-1:0] y,
  input  logic [3:0]       n,
  input  logic [AW-1:0]    i_addr,
  input  logic [1:0]       plane_mask,
  output logic             busy,
  output logic             done,
  output logic             collision,
  output logic [AW-1:0]    ram_addr,
  input  logic [7:0]       ram_dout,
  vram_blitter_if.master   vram,
  output blit_state_e      dbg_state_o
);

  // Handshake: a start pulse is taken only in IDLE (draw beats clear); busy
  // rises the next cycle and drops in the single done cycle, in which
  // starts are still ignored; collision is valid with done and held.
  blit_state_e      state_q, state_d;
  logic [HBITS-1:0] x_q, x_d;
  logic [VBITS-1:0] y_q, y_d;
  logic [3:0]       n_q, n_d;
  logic [AW-1:0]    i_q, i_d;
  logic [1:0]       mask_q, mask_d;
  logic [VBITS-1:0] row_q, row_d;
  logic [HBITS-1:0] col_q, col_d;
  logic             byte_q, byte_d;
  logic [15:0]      shift_q, shift_d;

  logic             wide;
  logic [4:0]       rows;
  logic [3:0]       last_col;
  logic [HBITS:0]   px, px_next;
  logic [VBITS:0]   py, py_next;
  logic             row_last;
  logic             clr_mode;
  logic [AW-1:0]    row_off;
  logic [HBITS+VBITS-1:0] rc_next;
  logic             adv, coll_clr, rmw_wr;
  rmw_op_e          rmw_op;

  assign wide     = (n_q == 4'd0);
  assign rows     = wide ? 5'(SPRITE16_ROWS) : {1'b0, n_q};
  assign last_col = wide ? 4'd15 : 4'd7;

  // One extra bit on each coordinate: a carry into it means off-screen.
  assign px       = {1'b0, x_q} + {1'b0, col_q};
  assign px_next  = px + (HBITS+1)'(1);
  assign py       = {1'b0, y_q} + {1'b0, row_q};
  assign py_next  = py + (VBITS+1)'(1);
  assign row_last = ((row_q + VBITS'(1)) == VBITS'(rows));
  assign rc_next  = {row_q, col_q} + (HBITS+VBITS)'(1);
  assign clr_mode = (state_q == ST_CLR_RD) || (state_q == ST_CLR_WR);

  always_comb begin
    row_off = AW'(row_q);
    if (wide) begin
      row_off = AW'({row_q, byte_q});
    end
  end

  assign ram_addr = i_q + row_off;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    n_d      = n_q;
    i_d      = i_q;
    mask_d   = mask_q;
    row_d    = row_q;
    col_d    = col_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    adv      = 1'b0;
    coll_clr = 1'b0;
    rmw_wr   = 1'b0;
    rmw_op   = RMW_XOR;

    case (state_q)
      ST_IDLE: begin
        if (draw_start || clr_start) begin
          x_d      = x;
          y_d      = y;
          n_d      = n;
          i_d      = i_addr;
          mask_d   = plane_mask;
          row_d    = '0;
          col_d    = '0;
          byte_d   = 1'b0;
          coll_clr = 1'b1;
          state_d  = draw_start ? ST_FETCH : ST_CLR_RD;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        if (wide && !byte_q) begin
          shift_d[15:8] = ram_dout;
          byte_d        = 1'b1;
          state_d       = ST_FETCH;
        end else begin
          if (wide) begin
            shift_d[7:0] = ram_dout;
            state_d      = shift_q[15] ? ST_PIX_RD : ST_SKIP;
          end else begin
            shift_d = {ram_dout, 8'h00};
            state_d = ram_dout[7] ? ST_PIX_RD : ST_SKIP;
          end
        end
      end
      ST_PIX_RD: state_d = ST_PIX_WR;
      ST_PIX_WR: begin
        rmw_wr = 1'b1;
        adv    = 1'b1;
      end
      ST_SKIP:   adv = 1'b1;
      ST_FINISH: state_d = ST_IDLE;
      ST_CLR_RD: begin
        rmw_op  = RMW_ANDN;
        state_d = ST_CLR_WR;
      end
      ST_CLR_WR: begin
        rmw_op = RMW_ANDN;
        rmw_wr = 1'b1;
        if (&{row_q, col_q}) begin
          state_d = ST_FINISH;
        end else begin
          {row_d, col_d} = rc_next;
          state_d        = ST_CLR_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Step to the next sprite bit; a clipped row ends the whole draw.
    if (adv) begin
      shift_d = {shift_q[14:0], 1'b0};
      if (col_q[3:0] == last_col) begin
        col_d  = '0;
        byte_d = 1'b0;
        if (row_last || py_next[VBITS]) begin
          state_d = ST_FINISH;
        end else begin
          row_d   = row_q + VBITS'(1);
          state_d = ST_FETCH;
        end
      end else begin
        col_d   = col_q + HBITS'(1);
        state_d = (shift_q[14] && !px_next[HBITS]) ? ST_PIX_RD : ST_SKIP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      byte_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      i_q     <= i_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      col_q   <= col_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
    end
  end

  vram_blitter_rmw_seq #(.HBITS(HBITS), .VBITS(VBITS)) u_rmw (
    .clk         (clk),
    .reset       (reset),
    .hpos_i      (clr_mode ? col_q : px[HBITS-1:0]),
    .vpos_i      (clr_mode ? row_q : py[VBITS-1:0]),
    .wr_i        (rmw_wr),
    .op_i        (rmw_op),
    .mask_i      (mask_q),
    .coll_clr_i  (coll_clr),
    .collision_o (collision),
    .vram        (vram)
  );

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done        = (state_q == ST_FINISH);
  assign dbg_state_o = state_q;

endmodule
